hazard_fwd_unit: RTL and testbench

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

---
 rtl/hazard_fwd_unit.sv | 145 ++++++++++++++
 tb/tb_hazard_fwd_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: EX-stage operand forwarding and load-use stall/flush control.
// Define HAZARD_FWD_STATS_EN to enable the saturating stall_cycles counter.

module hazard_fwd_lane #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rs_e,
  input  logic [ADDR_W-1:0] rd_m,
  input  logic              regwrite_m,
  input  logic [ADDR_W-1:0] rd_w,
  input  logic              regwrite_w,
  input  logic [DATA_W-1:0] rf_data,
  input  logic [DATA_W-1:0] alu_m,
  input  logic [DATA_W-1:0] result_w,
  output logic [1:0]        fwd,
  output logic [DATA_W-1:0] src
);
  logic hit_m, hit_w;

  // r0 is hardwired zero, so writes to it never forward
  assign hit_m = regwrite_m && (rd_m != '0) && (rd_m == rs_e);
  assign hit_w = regwrite_w && (rd_w != '0) && (rd_w == rs_e);
  assign fwd   = hit_m ? 2'b10 : (hit_w ? 2'b01 : 2'b00);

  always_comb begin
    src = rf_data;
    case (fwd)
      2'b01:   src = result_w;
      2'b10:   src = alu_m;
      default: src = rf_data;
    endcase
  end
endmodule

module hazard_fwd_unit #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs1_d,
  input  logic [ADDR_W-1:0] rs2_d,
  input  logic [ADDR_W-1:0] rs1_e,
  input  logic [ADDR_W-1:0] rs2_e,
  input  logic [ADDR_W-1:0] rd_e,
  input  logic              memtoreg_e,
  input  logic [ADDR_W-1:0] rd_m,
  input  logic              regwrite_m,
  input  logic [ADDR_W-1:0] rd_w,
  input  logic              regwrite_w,
  input  logic [DATA_W-1:0] rd1_e,
  input  logic [DATA_W-1:0] rd2_e,
  input  logic [DATA_W-1:0] alu_m,
  input  logic [DATA_W-1:0] result_w,
  output logic [DATA_W-1:0] srca_e,
  output logic [DATA_W-1:0] srcb_e,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_e,
  output logic [31:0]       stall_cycles
);
  localparam int CNT_W = $clog2(LOAD_LAT + 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] STALL = 1'b1;

  logic [1:0][ADDR_W-1:0] rs_e;
  logic [1:0][DATA_W-1:0] rf_data, src;
  logic [1:0][1:0]        fwd;

  assign rs_e    = {rs2_e, rs1_e};
  assign rf_data = {rd2_e, rd1_e};

  for (genvar g = 0; g < 2; g++) begin : g_lane
    hazard_fwd_lane #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lane (
      .rs_e       (rs_e[g]),
      .rd_m       (rd_m),
      .regwrite_m (regwrite_m),
      .rd_w       (rd_w),
      .regwrite_w (regwrite_w),
      .rf_data    (rf_data[g]),
      .alu_m      (alu_m),
      .result_w   (result_w),
      .fwd        (fwd[g]),
      .src        (src[g])
    );
  end

  assign srca_e = src[0];
  assign srcb_e = src[1];
  assign fwd_a  = fwd[0];
  assign fwd_b  = fwd[1];

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             lu_hazard, stall;

  assign lu_hazard = memtoreg_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  // Gated by reset so the controls drop immediately even with a live hazard
  assign stall   = !reset && ((state == STALL) || lu_hazard);
  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_e = stall;

  // The IDLE hazard cycle is the first stall cycle; STALL covers the remaining LOAD_LAT-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lu_hazard && (LOAD_LAT > 1)) begin
            state <= STALL;
            cnt   <= CNT_W'(LOAD_LAT - 1);
          end
        end
        STALL: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_FWD_STATS_EN
  logic [31:0] stat_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   stat_q <= '0;
    else if (stall && (stat_q != 32'hFFFF_FFFF)) stat_q <= stat_q + 32'd1;
  end

  assign stall_cycles = stat_q;
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: three instances (LOAD_LAT 1..3) on shared stimulus,
// compared each cycle against a remaining-stall-count model, plus directed cases.

module tb_hazard_fwd_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic        memtoreg_e, regwrite_m, regwrite_w;
  logic [31:0] rd1_e, rd2_e, alu_m, result_w;

  logic [31:0] srca[3], srcb[3], sc[3];
  logic [1:0]  fa[3], fb[3];
  logic        sf[3], sd[3], fe[3];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    hazard_fwd_unit #(.DATA_W(32), .ADDR_W(5), .LOAD_LAT(k + 1)) u_dut (
      .clk(clk), .reset(reset),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
      .memtoreg_e(memtoreg_e), .rd_m(rd_m), .regwrite_m(regwrite_m),
      .rd_w(rd_w), .regwrite_w(regwrite_w),
      .rd1_e(rd1_e), .rd2_e(rd2_e), .alu_m(alu_m), .result_w(result_w),
      .srca_e(srca[k]), .srcb_e(srcb[k]), .fwd_a(fa[k]), .fwd_b(fb[k]),
      .stall_f(sf[k]), .stall_d(sd[k]), .flush_e(fe[k]), .stall_cycles(sc[k])
    );
  end

  int checks = 0;
  int errors = 0;

  // Model: stall cycles still owed after the current one, and total stall cycles seen
  int          rem[3];
  int unsigned stat[3];
  logic [7:0]  hist[3];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit lu();
    return memtoreg_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
  endfunction

  function automatic logic [1:0] exp_fwd(logic [4:0] rs);
    if (regwrite_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (regwrite_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_src(logic [1:0] sel, logic [31:0] rf);
    if (sel == 2'b10) return alu_m;
    if (sel == 2'b01) return result_w;
    return rf;
  endfunction

  function automatic bit exp_stall(int k);
    return !reset && (rem[k] > 0 || lu());
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin rem[k] = 0; stat[k] = 0; end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      logic [31:0] es;
`ifdef HAZARD_FWD_STATS_EN
      es = stat[k];
`else
      es = 32'd0;
`endif
      chk($sformatf("stall_f[%0d]", k), sf[k], exp_stall(k));
      chk($sformatf("stall_d[%0d]", k), sd[k], exp_stall(k));
      chk($sformatf("flush_e[%0d]", k), fe[k], exp_stall(k));
      chk($sformatf("fwd_a[%0d]", k), fa[k], exp_fwd(rs1_e));
      chk($sformatf("fwd_b[%0d]", k), fb[k], exp_fwd(rs2_e));
      chk($sformatf("srca_e[%0d]", k), srca[k], exp_src(exp_fwd(rs1_e), rd1_e));
      chk($sformatf("srcb_e[%0d]", k), srcb[k], exp_src(exp_fwd(rs2_e), rd2_e));
      chk($sformatf("stall_cycles[%0d]", k), sc[k], es);
    end
  endtask

  task automatic advance();
    for (int k = 0; k < 3; k++) begin
      bit st;
      st = exp_stall(k);
      if (reset) begin
        rem[k] = 0; stat[k] = 0;
      end else begin
        if (st && stat[k] != 32'hFFFF_FFFF) stat[k]++;
        if (rem[k] > 0) rem[k]--;
        else if (lu()) rem[k] = k;  // LOAD_LAT-1 more cycles after this one
      end
    end
  endtask

  // Check at negedge, record stall history, step model at posedge, return at posedge+1
  task automatic tick();
    @(negedge clk);
    check_all();
    for (int k = 0; k < 3; k++) hist[k] = {hist[k][6:0], sd[k]};
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic clear_hz();
    memtoreg_e = 1'b0; rd_e = 5'd0; rs1_d = 5'd0; rs2_d = 5'd0;
  endtask

  task automatic set_hz();
    memtoreg_e = 1'b1; rd_e = 5'd7; rs1_d = 5'd2; rs2_d = 5'd7;
  endtask

  task automatic do_reset();
    reset = 1'b1; model_clear();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) hist[k] = '0;
  endtask

  typedef struct {
    logic [4:0] rs1_e, rs2_e, rd_m;
    logic       regwrite_m;
    logic [4:0] rd_w;
    logic       regwrite_w;
    logic [1:0] exp_a, exp_b;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{5'd5,  5'd3,  5'd5,  1'b1, 5'd5,  1'b1, 2'b10, 2'b00};
    tbl[1] = '{5'd4,  5'd0,  5'd0,  1'b1, 5'd4,  1'b1, 2'b01, 2'b00};
    tbl[2] = '{5'd6,  5'd6,  5'd9,  1'b1, 5'd6,  1'b1, 2'b01, 2'b01};
    tbl[3] = '{5'd6,  5'd9,  5'd9,  1'b0, 5'd9,  1'b1, 2'b00, 2'b01};
    tbl[4] = '{5'd7,  5'd8,  5'd7,  1'b1, 5'd8,  1'b0, 2'b10, 2'b00};
    tbl[5] = '{5'd0,  5'd0,  5'd0,  1'b1, 5'd0,  1'b1, 2'b00, 2'b00};
    tbl[6] = '{5'd12, 5'd12, 5'd12, 1'b1, 5'd3,  1'b1, 2'b10, 2'b10};
    tbl[7] = '{5'd31, 5'd30, 5'd30, 1'b1, 5'd31, 1'b1, 2'b01, 2'b10};

    reset = 1'b1;
    clear_hz();
    rs1_e = 5'd0; rs2_e = 5'd0; rd_m = 5'd0; rd_w = 5'd0;
    regwrite_m = 1'b0; regwrite_w = 1'b0;
    rd1_e = 32'h1111_1111; rd2_e = 32'h2222_2222;
    alu_m = 32'hAAAA_0000; result_w = 32'h0000_5555;
    model_clear();

    // Reset state, with a live hazard on the inputs
    set_hz();
    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_stall_d[%0d]", k), sd[k], 1'b0);
      chk($sformatf("rst_stats[%0d]", k), sc[k], 32'd0);
    end
    clear_hz();
    do_reset();

    // Forwarding vectors
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ea, eb;
      rs1_e = tbl[i].rs1_e; rs2_e = tbl[i].rs2_e; rd_m = tbl[i].rd_m;
      regwrite_m = tbl[i].regwrite_m; rd_w = tbl[i].rd_w; regwrite_w = tbl[i].regwrite_w;
      tick();
      ea = (tbl[i].exp_a == 2'b10) ? 32'hAAAA_0000 : (tbl[i].exp_a == 2'b01) ? 32'h0000_5555 : 32'h1111_1111;
      eb = (tbl[i].exp_b == 2'b10) ? 32'hAAAA_0000 : (tbl[i].exp_b == 2'b01) ? 32'h0000_5555 : 32'h2222_2222;
      chk($sformatf("tbl%0d_fwd_a", i), fa[0], tbl[i].exp_a);
      chk($sformatf("tbl%0d_fwd_b", i), fb[0], tbl[i].exp_b);
      chk($sformatf("tbl%0d_srca", i), srca[0], ea);
      chk($sformatf("tbl%0d_srcb", i), srcb[0], eb);
    end
    regwrite_m = 1'b0; regwrite_w = 1'b0;

    // Single load-use hazard: LOAD_LAT stall cycles then clear
    do_reset();
    set_hz();
    tick();
    clear_hz();
    for (int c = 0; c < 5; c++) tick();
    chk("single_lat1", hist[0][5:0], 6'b100000);
    chk("single_lat2", hist[1][5:0], 6'b110000);
    chk("single_lat3", hist[2][5:0], 6'b111000);
`ifdef HAZARD_FWD_STATS_EN
    chk("single_lat3_stats", sc[2], 32'd3);
`else
    chk("single_lat3_stats", sc[2], 32'd0);
`endif

    // Back-to-back: new hazard in the first IDLE cycle after a LOAD_LAT=2 stall
    do_reset();
    set_hz(); tick();
    clear_hz(); tick();
    set_hz(); tick();
    clear_hz();
    for (int c = 0; c < 4; c++) tick();
    chk("b2b_lat2", hist[1][6:0], 7'b1111000);

    // Reset in the second stall cycle of LOAD_LAT=3
    do_reset();
    set_hz(); tick();
    clear_hz();
    #2;
    chk("pre_rst_stall_lat3", sd[2], 1'b1);
    reset = 1'b1;
    model_clear();
    #1;
    chk("midrst_stall_f", sf[2], 1'b0);
    chk("midrst_stall_d", sd[2], 1'b0);
    chk("midrst_flush_e", fe[2], 1'b0);
    chk("midrst_stats", sc[2], 32'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) hist[k] = '0;
    tick(); tick();
    chk("post_rst_idle", hist[2][1:0], 2'b00);
    set_hz(); tick();
    clear_hz();
    for (int c = 0; c < 3; c++) tick();
    chk("post_rst_fresh", hist[2][3:0], 4'b1110);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 39) == 0);
      if (reset) model_clear();
      rs1_d      = 5'($urandom_range(0, 7));
      rs2_d      = 5'($urandom_range(0, 7));
      rs1_e      = 5'($urandom_range(0, 7));
      rs2_e      = 5'($urandom_range(0, 7));
      rd_e       = 5'($urandom_range(0, 7));
      rd_m       = 5'($urandom_range(0, 7));
      rd_w       = 5'($urandom_range(0, 7));
      memtoreg_e = 1'($urandom_range(0, 1));
      regwrite_m = 1'($urandom_range(0, 1));
      regwrite_w = 1'($urandom_range(0, 1));
      rd1_e      = $urandom;
      rd2_e      = $urandom;
      alu_m      = $urandom;
      result_w   = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
